// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter with round-robin grant, a three-state
// IDLE/REQ/ACK handshake and an optional wait timeout.
module periph_bus_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m1_req,
  input  logic            m0_we,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [1:0]      m0_size,
  input  logic [1:0]      m1_size,
  output logic            m0_done,
  output logic            m1_done,
  output logic            m0_err,
  output logic            m1_err,
  output logic [XLEN-1:0] m_rdata,
  output logic [XLEN-1:0] io_addr,
  output logic [XLEN-1:0] io_wdata,
  output logic            io_read,
  output logic            io_write,
  output logic [1:0]      io_byte_size,
  output logic            read_ready,
  input  logic [XLEN-1:0] io_rdata,
  input  logic            io_ready
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic            winner_q, winner_d;
  logic            rr_q, rr_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      done_q, done_d;
  logic            err_q, err_d;
  logic            grant;

  // rr_q=1 favours m1 on a tie; it is rewritten to favour whoever was not just served.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    done_d   = 2'b00;
    err_d    = 1'b0;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant    = (m0_req && m1_req) ? rr_q : m1_req;
          winner_d = grant;
          we_d     = grant ? m1_we    : m0_we;
          addr_d   = grant ? m1_addr  : m0_addr;
          wdata_d  = grant ? m1_wdata : m0_wdata;
          size_d   = grant ? m1_size  : m0_size;
          cnt_d    = 16'd0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (io_ready) begin
          rdata_d          = io_rdata;
          done_d[winner_q] = 1'b1;
          state_d          = ACK;
        end else if (TIMEOUT_EN && (({1'b0, cnt_q} + 17'd1) == TIMEOUT_LIM)) begin
          rdata_d          = '0;
          done_d[winner_q] = 1'b1;
          err_d            = 1'b1;
          cnt_d            = cnt_q + 16'd1;
          state_d          = ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK: begin
        if (!io_ready) begin
          rr_d    = ~winner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      rr_q     <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      cnt_q    <= 16'd0;
      rdata_q  <= '0;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode from state so reset clears them without waiting for a clock.
  assign io_read      = (state_q == REQ) && !we_q;
  assign io_write     = (state_q == REQ) && we_q;
  assign io_addr      = (state_q == IDLE) ? '0 : addr_q;
  assign io_wdata     = (state_q == IDLE) ? '0 : wdata_q;
  assign io_byte_size = (state_q == IDLE) ? 2'b00 : size_q;
  assign read_ready   = (state_q == ACK);
  assign m0_done      = done_q[0];
  assign m1_done      = done_q[1];
  assign m0_err       = done_q[0] & err_q;
  assign m1_err       = done_q[1] & err_q;
  assign m_rdata      = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: a driver predicts grant order and
// completions, a peripheral responder and a done monitor check against queues.
module tb_periph_bus_arbiter;

  localparam int TO = 4;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          lat;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          master;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [1:0]  m0_size = '0, m1_size = '0;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m_rdata, io_addr, io_wdata;
  logic        io_read, io_write, read_ready;
  logic [1:0]  io_byte_size;
  logic [31:0] io_rdata = '0;
  logic        io_ready = 1'b0;

  int   compared = 0;
  int   mismatched = 0;
  int   cycleCount = 0;
  bit   lastServed = 1'b0;
  bit   respEnable = 1'b1;
  txn_t busQ[$];
  exp_t doneQ[$];

  periph_bus_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_size(m0_size), .m1_size(m1_size),
    .m0_done(m0_done), .m1_done(m1_done), .m0_err(m0_err), .m1_err(m1_err),
    .m_rdata(m_rdata), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_read(io_read), .io_write(io_write), .io_byte_size(io_byte_size),
    .read_ready(read_ready), .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  function automatic txn_t mkTxn(bit we, logic [31:0] addr, logic [31:0] wdata,
                                 logic [1:0] size, int lat, logic [31:0] rdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.size = size; t.lat = lat; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t randTxn();
    return mkTxn(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 5), $urandom);
  endfunction

  // Expected completion: timeout when the peripheral would answer after TO waited cycles.
  task automatic pushTxn(input bit m, input txn_t t);
    exp_t e;
    busQ.push_back(t);
    e.master = m;
    e.err    = (t.lat >= TO);
    e.rdata  = e.err ? 32'h0 : t.rdata;
    doneQ.push_back(e);
  endtask

  // Issue one round of requests; each master holds req until its own done.
  task automatic applyStimulus(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
    bit first;
    int pend;
    first = (r0 && r1) ? ~lastServed : r1;
    pushTxn(first, first ? t1 : t0);
    if (r0 && r1) pushTxn(~first, first ? t0 : t1);
    lastServed = (r0 && r1) ? ~first : first;
    m0_we = t0.we; m0_addr = t0.addr; m0_wdata = t0.wdata; m0_size = t0.size; m0_req = r0;
    m1_we = t1.we; m1_addr = t1.addr; m1_wdata = t1.wdata; m1_size = t1.size; m1_req = r1;
    pend = int'(r0) + int'(r1);
    for (int c = 0; c < 200 && pend > 0; c++) begin
      @(negedge pclk);
      if (m0_done && m0_req) begin m0_req = 1'b0; pend--; end
      if (m1_done && m1_req) begin m1_req = 1'b0; pend--; end
    end
    if (pend != 0) begin
      checkOutput("round_budget", pend, 0);
      finishRun();
    end
  endtask

  task automatic runHeld(input int n, input txn_t t);
    int count = 0;
    int prev = 0;
    for (int i = 0; i < n; i++) pushTxn(1'b0, t);
    lastServed = 1'b0;
    m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; m0_size = t.size; m0_req = 1'b1;
    m1_req = 1'b0;
    for (int c = 0; c < 50 * n && count < n; c++) begin
      @(negedge pclk);
      if (m0_done) begin
        if (count > 0) checkOutput("b2b_spacing", cycleCount - prev, 3);
        prev = cycleCount;
        count++;
        if (count == n) m0_req = 1'b0;
      end
    end
    if (count != n) begin
      checkOutput("held_budget", count, n);
      finishRun();
    end
  endtask

  // Peripheral model: replays queued transactions, checks bus fields and strobe length.
  always @(negedge pclk) begin : responder
    static bit   prevStrobe = 1'b0;
    static int   reqCycles = 0;
    static txn_t cur = '{default: 0};
    bit strobe;
    if (!respEnable) begin
      io_ready   = 1'b0;
      prevStrobe = 1'b0;
    end else begin
      strobe = io_read | io_write;
      if (strobe && !prevStrobe) begin
        reqCycles = 0;
        if (busQ.size() == 0) checkOutput("bus_unexpected", 1, 0);
        else cur = busQ.pop_front();
      end
      if (strobe) begin
        checkOutput("io_addr", io_addr, cur.addr);
        checkOutput("io_wdata", io_wdata, cur.wdata);
        checkOutput("io_byte_size", {30'b0, io_byte_size}, {30'b0, cur.size});
        checkOutput("io_write", {31'b0, io_write}, {31'b0, cur.we});
        checkOutput("io_read", {31'b0, io_read}, {31'b0, ~cur.we});
        checkOutput("read_ready_req", {31'b0, read_ready}, 0);
        if (reqCycles == cur.lat) begin
          io_ready = 1'b1;
          io_rdata = cur.rdata;
        end else begin
          io_ready = 1'b0;
          io_rdata = $urandom;
        end
        reqCycles++;
      end else begin
        if (prevStrobe) begin
          checkOutput("read_ready_ack", {31'b0, read_ready}, 1);
          checkOutput("req_cycles", reqCycles, (cur.lat >= TO) ? TO : cur.lat + 1);
        end else begin
          checkOutput("idle_addr", io_addr, 0);
          checkOutput("idle_wdata", io_wdata, 0);
          checkOutput("idle_read_ready", {31'b0, read_ready}, 0);
        end
        io_ready = 1'b0;
      end
      prevStrobe = strobe;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge pclk) begin : doneMonitor
    exp_t e;
    checkOutput("done_both", {31'b0, m0_done & m1_done}, 0);
    if (m0_done || m1_done) begin
      if (doneQ.size() == 0) begin
        checkOutput("done_unexpected", 1, 0);
      end else begin
        e = doneQ.pop_front();
        checkOutput("done_master", {31'b0, m1_done}, {31'b0, e.master});
        checkOutput("done_err", {31'b0, m0_done ? m0_err : m1_err}, {31'b0, e.err});
        checkOutput("m_rdata", m_rdata, e.rdata);
      end
    end else begin
      checkOutput("err_without_done", {31'b0, m0_err | m1_err}, 0);
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_io_read"}, {31'b0, io_read}, 0);
    checkOutput({tag, "_io_write"}, {31'b0, io_write}, 0);
    checkOutput({tag, "_io_addr"}, io_addr, 0);
    checkOutput({tag, "_io_wdata"}, io_wdata, 0);
    checkOutput({tag, "_io_size"}, {30'b0, io_byte_size}, 0);
    checkOutput({tag, "_read_ready"}, {31'b0, read_ready}, 0);
    checkOutput({tag, "_done"}, {30'b0, m1_done, m0_done}, 0);
    checkOutput({tag, "_err"}, {30'b0, m1_err, m0_err}, 0);
    checkOutput({tag, "_m_rdata"}, m_rdata, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    checkOutput("global_timeout", 0, 1);
    finishRun();
  end

  initial begin : main
    txn_t z;
    int sel;
    z = mkTxn(1'b0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
    repeat (2) @(negedge pclk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge pclk);

    // First tie after reset goes to m1, then m0.
    applyStimulus(1'b1, 1'b1, mkTxn(1'b1, 32'h1000_0000, 32'hAAAA_0000, 2'd2, 1, 32'h1111_1111),
                  mkTxn(1'b0, 32'h2000_0000, 32'h0, 2'd1, 0, 32'h2222_2222));
    // m1 read with two wait cycles.
    applyStimulus(1'b0, 1'b1, z, mkTxn(1'b0, 32'h2000_0010, 32'h0, 2'd2, 2, 32'hDEAD_BEEF));
    // m0 word write.
    applyStimulus(1'b1, 1'b0, mkTxn(1'b1, 32'h1000_0004, 32'h1234_5678, 2'd2, 1, 32'h5555_0000), z);
    // Timeout, ready coinciding with the timeout cycle, and one cycle past it.
    applyStimulus(1'b1, 1'b0, mkTxn(1'b0, 32'h3000_0000, 32'h0, 2'd0, 6, 32'h7777_7777), z);
    applyStimulus(1'b1, 1'b0, mkTxn(1'b0, 32'h3000_0004, 32'h0, 2'd0, TO - 1, 32'h8888_8888), z);
    applyStimulus(1'b0, 1'b1, z, mkTxn(1'b1, 32'h3000_0008, 32'h9, 2'd3, TO, 32'h9999_9999));
    // Continuous m0 request: one transfer every three cycles.
    runHeld(4, mkTxn(1'b0, 32'h4000_0000, 32'h0, 2'd2, 0, 32'hCAFE_F00D));

    // Reset in the middle of a request: outputs clear at once, no done for it.
    respEnable = 1'b0;
    m0_we = 1'b0; m0_addr = 32'h5000_0000; m0_size = 2'd2; m0_req = 1'b1;
    for (int c = 0; c < 5 && !io_read; c++) @(negedge pclk);
    checkOutput("abort_strobe_seen", {31'b0, io_read}, 1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("abort");
    m0_req = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    lastServed = 1'b0;
    respEnable = 1'b1;
    @(negedge pclk);
    applyStimulus(1'b1, 1'b0, mkTxn(1'b0, 32'h5000_0000, 32'h0, 2'd2, 1, 32'h0BAD_CAFE), z);

    // Randomized rounds against the arbitration and completion model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      applyStimulus(sel != 1, sel != 0, randTxn(), randTxn());
    end

    repeat (3) @(negedge pclk);
    checkOutput("busQ_drained", busQ.size(), 0);
    checkOutput("doneQ_drained", doneQ.size(), 0);
    finishRun();
  end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameter XLEN, 32, data/address width; equals `MAX_BIT_POS+1.
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum wait in REQ for io_ready; 0 disables timeout; range 0-65535.
REQ-003 pclk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 m0_req, m1_req  in  1 each  transfer request; m0 = instruction fetch, m1 = load/store.
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr, m0_wdata, m1_wdata  in  XLEN each  request address and write data.
REQ-008 m0_size, m1_size  in  2 each  byte size code, passed to io_byte_size unchanged.
REQ-009 m0_done, m1_done  out  1 each  one-cycle completion pulse.
REQ-010 m0_err, m1_err  out  1 each  valid with done; 1 = timeout.
REQ-011 m_rdata  out  XLEN  read data, valid with either done pulse.
REQ-012 io_addr, io_wdata  out  XLEN; io_read, io_write  out  1; io_byte_size  out  2; read_ready  out  1.
REQ-013 io_rdata  in  XLEN; io_ready  in  1  from peripheral bus.

Function
REQ-014 The block SHALL implement FSM states IDLE, REQ, ACK.
REQ-015 IDLE: when any mX_req=1, the block SHALL select a winner, register its addr/wdata/size/we and enter REQ; io_read or io_write SHALL assert on the following cycle.
REQ-016 Arbitration SHALL be round-robin: the master not served last wins a tie; the first tie after reset goes to m1.
REQ-017 A single requester SHALL win regardless of the round-robin pointer.
REQ-018 In REQ, io_addr, io_wdata, io_byte_size and strobes SHALL stay constant; io_read = ~we and io_write = we; exactly one strobe is high.
REQ-019 In REQ, on io_ready=1 the block SHALL register io_rdata into m_rdata, pulse winner's done for one cycle with err=0, and enter ACK.
REQ-020 In ACK, io_read and io_write SHALL be 0 and read_ready SHALL be 1.
REQ-021 ACK SHALL hold until io_ready=0, then return to IDLE and toggle the round-robin pointer.
REQ-022 Minimum transaction length SHALL be 3 cycles (IDLE, REQ, ACK); a new grant is accepted in the IDLE cycle that follows.
REQ-023 A 16-bit wait counter SHALL clear on entering REQ and increment each REQ cycle without io_ready.
REQ-024 If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES without io_ready, the block SHALL drop the strobes, pulse done with err=1 and m_rdata=0, and enter ACK.
REQ-025 io_ready and timeout in the same cycle SHALL complete normally with err=0.
REQ-026 For writes, m_rdata SHALL still capture io_rdata; masters ignore it.
REQ-027 Deasserting mX_req while granted SHALL NOT abort the transfer; done still pulses.
REQ-028 A master SHALL hold req until its done; a req still high after done is a new request.
REQ-029 In IDLE, io_addr and io_wdata SHALL be 0, strobes 0 and read_ready 0.
REQ-030 done and err outputs SHALL never be asserted for both masters in the same cycle.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with all outputs 0, counter 0, and round-robin pointer set to favour m1.
REQ-032 On reset assertion mid-transfer, strobes SHALL drop immediately and no done SHALL pulse for the aborted transfer.

Verification
REQ-033 m1 read 0x2000_0010, io_ready after 2 cycles with io_rdata 0xDEADBEEF -> io_read high for 3 cycles, m1_done=1, m1_err=0, m_rdata=0xDEADBEEF, read_ready high until io_ready falls.
REQ-034 m0 and m1 both request from reset -> m1 served first, then m0, with io_addr changing only in IDLE.
REQ-035 m0 write 0x1000_0004 data 0x12345678 size 2 -> io_write=1, io_wdata=0x12345678, io_byte_size=2, m0_done after io_ready.
REQ-036 TIMEOUT_CYCLES=4 with io_ready held 0 -> strobe dropped after 4 REQ cycles, m0_done=1, m0_err=1, m_rdata=0.
REQ-037 rst_n pulled low during REQ -> all outputs 0 asynchronously, no done pulse; after release, a fresh m0 request completes normally.
REQ-038 m0_req held continuously with m1 idle -> back-to-back transfers, one every 3 cycles, all granted to m0.
